// File: rtl/ringosc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : ringosc_freq_meter
// Brief    : Gated edge counter for one of NCH asynchronous ring-oscillator
//            inputs, with saturating result and continuous-window mode.
// Revision : 1.0 - initial release
// ============================================================================
module ringosc_freq_meter #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int GATE_MIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NCH-1:0]           osc_in,
    input  logic [$clog2(NCH)-1:0]   ch_sel,
    input  logic [3:0]               gate_sel,
    input  logic                     cont,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     ovf
);

    localparam int c_CH_W  = $clog2(NCH);
    localparam int c_WIN_W = GATE_MIN + 16;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_MEAS = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [c_CH_W:0]    c_NCH     = (c_CH_W+1)'(NCH);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_WIN_W-1:0] c_WIN_ONE = {{(c_WIN_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_load;

    logic [NCH-1:0]     r_sync1;
    logic [NCH-1:0]     r_sync2;
    logic [NCH-1:0]     r_prev;

    logic [c_CH_W-1:0]  r_ch;
    logic [3:0]         r_gate;
    logic               r_cont;
    logic [c_CH_W-1:0]  w_ch_map;

    logic [1:0]         r_arm_cnt;
    logic [c_WIN_W-1:0] r_win;
    logic [c_WIN_W-1:0] w_win_max;
    logic [7:0]         w_shamt;
    logic               w_win_last;

    logic [CNT_W-1:0]   r_acc;
    logic               r_acc_ovf;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic               w_edge;

    // Out-of-range channel requests fall back to channel 0.
    assign w_ch_map   = ({1'b0, ch_sel} >= c_NCH) ? '0 : ch_sel;
    assign w_edge     = r_sync2[r_ch] & ~r_prev[r_ch];

    assign w_shamt    = 8'(GATE_MIN) + {4'b0000, r_gate};
    assign w_win_max  = (c_WIN_ONE << w_shamt) - c_WIN_ONE;
    assign w_win_last = (r_win == w_win_max);

    assign w_acc_nxt  = (w_edge && (r_acc != c_CNT_MAX)) ? (r_acc + c_CNT_ONE) : r_acc;
    assign w_ovf_nxt  = r_acc_ovf | (w_edge && (r_acc == c_CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        busy        = (r_state != c_IDLE);
        done        = (r_state == c_DONE);
        case (r_state)
            c_IDLE: begin
                if (start && ena) begin
                    w_state_nxt = c_ARM;
                    w_load      = 1'b1;
                end
            end
            c_ARM: begin
                if (!ena) begin
                    w_state_nxt = c_IDLE;
                end else if (r_arm_cnt == 2'd2) begin
                    w_state_nxt = c_MEAS;
                end
            end
            c_MEAS: begin
                if (!ena) begin
                    w_state_nxt = c_IDLE;
                end else if (w_win_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                // Back-to-back windows skip ARM; the DONE cycle itself is dead time.
                if (ena && r_cont) begin
                    w_state_nxt = c_MEAS;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_ch      <= '0;
            r_gate    <= '0;
            r_cont    <= 1'b0;
            r_arm_cnt <= '0;
            r_win     <= '0;
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_load) begin
                r_ch   <= w_ch_map;
                r_gate <= gate_sel;
                r_cont <= cont;
            end

            r_arm_cnt <= (r_state == c_ARM) ? (r_arm_cnt + 2'd1) : 2'd0;

            // Holding the accumulator clear outside MEASURE gives a clean start on entry.
            if (r_state == c_MEAS) begin
                r_win     <= r_win + c_WIN_ONE;
                r_acc     <= w_acc_nxt;
                r_acc_ovf <= w_ovf_nxt;
            end else begin
                r_win     <= '0;
                r_acc     <= '0;
                r_acc_ovf <= 1'b0;
            end

            // Result is published on the MEASURE->DONE edge so it is valid during DONE.
            if ((r_state == c_MEAS) && ena && w_win_last) begin
                count <= w_acc_nxt;
                ovf   <= w_ovf_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ringosc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ringosc_freq_meter
// Brief    : Directed and randomized bench; expected counts come from the
//            recorded oscillator waveform and the window timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ringosc_freq_meter;

    localparam int c_MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] osc_in;
    logic [1:0] ch_sel;
    logic [3:0] gate_sel;
    logic       cont;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       ovf;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] osc_hist [c_MAXC];
    int         per [4];
    int         ph  [4];
    int         exp_count = 0;
    int         exp_ovf   = 0;

    ringosc_freq_meter #(.NCH(4), .CNT_W(4), .GATE_MIN(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .osc_in   (osc_in),
        .ch_sel   (ch_sel),
        .gate_sel (gate_sel),
        .cont     (cont),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // per<0: random bits, per==0: held low, else square wave of that period.
    function automatic logic [3:0] gen(input int t);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            if (per[c] < 0)       v[c] = 1'($urandom);
            else if (per[c] > 0)  v[c] = (((t + ph[c]) % per[c]) < (per[c] / 2));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= c_MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, c_MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        osc_in        = gen(cyc);
        osc_hist[cyc] = osc_in;
    endtask

    // Rising edges seen by the meter in cycles t0..t1 (2-flop sync + edge detect).
    function automatic int edges(input int ch, input int t0, input int t1);
        int n = 0;
        for (int t = t0; t <= t1; t++) begin
            if (osc_hist[t-2][ch] && !osc_hist[t-3][ch]) n++;
        end
        return n;
    endfunction

    task automatic set_expect(input int e);
        exp_count = (e > 15) ? 15 : e;
        exp_ovf   = (e > 15) ? 1 : 0;
    endtask

    task automatic run_meas(input int ch, input int gsel, input bit hold, input bit scr, input string tag);
        int s;
        int w;
        s        = cyc;
        w        = 1 << (4 + gsel);
        ch_sel   = ch[1:0];
        gate_sel = gsel[3:0];
        cont     = 1'b0;
        ena      = 1'b1;
        start    = 1'b1;
        for (int k = 1; k <= 4 + w; k++) begin
            tick();
            if (!hold) start = 1'b0;
            if (scr) begin
                ch_sel   = 2'($urandom);
                gate_sel = 4'($urandom);
                cont     = 1'($urandom);
            end
            chk({tag, "_busy"}, busy, 1);
            if (k < 4 + w) chk({tag, "_done_early"}, done, 0);
        end
        set_expect(edges(ch, s + 4, s + 3 + w));
        chk({tag, "_done"}, done, 1);
        chk({tag, "_count"}, count, exp_count);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        tick();
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_done_end"}, done, 0);
    endtask

    initial begin
        int s;
        int e;
        int win;
        rst = 1'b1; ena = 1'b0; cont = 1'b0; start = 1'b0;
        ch_sel = '0; gate_sel = '0; osc_in = '0; osc_hist[0] = '0;
        for (int c = 0; c < 4; c++) begin per[c] = 0; ph[c] = 0; end
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0; ena = 1'b1;
        tick();

        per[2] = 4;
        run_meas(2, 0, 1'b0, 1'b0, "basic");
        chk("basic_count4", count, 4);
        chk("basic_ovf0", ovf, 0);

        per[0] = 2;
        run_meas(0, 2, 1'b0, 1'b0, "sat");
        chk("sat_count15", count, 15);
        chk("sat_ovf1", ovf, 1);

        per[0] = 0; per[2] = 0; per[1] = 6;
        run_meas(3, 1, 1'b0, 1'b1, "iso");
        chk("iso_zero", count, 0);

        per[1] = 0; per[2] = 4;
        run_meas(2, 0, 1'b1, 1'b0, "hold1");
        run_meas(2, 0, 1'b0, 1'b0, "hold2");

        // Continuous mode: three windows, then abort inside the fourth.
        per[2] = 8; per[1] = 6;
        s = cyc; ch_sel = 2'd2; gate_sel = 4'd0; cont = 1'b1; start = 1'b1; ena = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            tick();
            start = 1'b0; cont = 1'b0; ch_sel = 2'($urandom);
            chk("cont_busy", busy, 1);
            if (k >= 20 && ((k - 20) % 17) == 0) begin
                win = (k - 20) / 17;
                e   = edges(2, s + 4 + win * 17, s + 19 + win * 17);
                set_expect(e);
                chk("cont_done", done, 1);
                chk("cont_count", count, exp_count);
                chk("cont_count2", count, 2);
            end else begin
                chk("cont_done_low", done, 0);
            end
        end
        ena = 1'b0;
        tick();
        chk("cont_abort_busy", busy, 0);
        chk("cont_abort_count", count, exp_count);
        ena = 1'b1;
        run_meas(2, 0, 1'b0, 1'b0, "cont_after");

        // Abort at the 10th MEASURE cycle.
        per[1] = 4;
        ch_sel = 2'd1; gate_sel = 4'd1; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            start = 1'b0;
            chk("abort_busy", busy, 1);
            chk("abort_done_low", done, 0);
        end
        ena = 1'b0;
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_count_hold", count, exp_count);
        chk("abort_ovf_hold", ovf, exp_ovf);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ena_low_start_ignored", busy, 0);
            chk("ena_low_no_done", done, 0);
        end
        start = 1'b0; ena = 1'b1;
        tick();

        // Reset in the middle of a window.
        per[3] = 6;
        ch_sel = 2'd3; gate_sel = 4'd0; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ovf", ovf, 0);
        rst = 1'b0;
        tick();
        chk("midrst_idle", busy, 0);
        run_meas(3, 0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 12; i++) begin
            bit hold;
            for (int c = 0; c < 4; c++) begin
                int r;
                r     = $urandom_range(0, 7);
                per[c] = (r == 0) ? -1 : 2 * r;
                ph[c]  = $urandom_range(0, 15);
            end
            hold = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_meas($urandom_range(0, 3), $urandom_range(0, 2), hold, 1'($urandom_range(0, 1)), "rand");
        end
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
